// File: rtl/decode_rename_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_rename_queue_pkg
// Brief  : Shared widths and bundle type for the Decode->Rename queue.
// Rev    : 1.0  initial release
// ============================================================================
package decode_rename_queue_pkg;

    localparam int c_DEC_PKT_WIDTH = 16;
    localparam int c_BRANCH_COUNT  = 3;
    localparam int c_BUNDLE_SLOTS  = 4;
    localparam int c_BUNDLE_W      = c_BUNDLE_SLOTS * c_DEC_PKT_WIDTH + c_BRANCH_COUNT;

    typedef struct packed {
        logic [c_BUNDLE_SLOTS-1:0][c_DEC_PKT_WIDTH-1:0] pkt;
        logic [c_BRANCH_COUNT-1:0]                      bc;
    } bundle_t;

endpackage
`default_nettype wire

// File: rtl/decode_rename_queue_if.sv
`default_nettype none
// ============================================================================
// Module : decode_rename_queue_if
// Brief  : Decode-side and Rename-side handshake bundle for the rename queue.
// Rev    : 1.0  initial release
// ============================================================================
interface decode_rename_queue_if
    import decode_rename_queue_pkg::*;
#(
    parameter int PKT_W     = c_DEC_PKT_WIDTH,
    parameter int BC_W      = c_BRANCH_COUNT,
    parameter int DEPTH_LOG = 2
);
    logic                      flush_i;
    logic                      decodeReady_i;
    logic [PKT_W-1:0]          decodedPacket0_i;
    logic [PKT_W-1:0]          decodedPacket1_i;
    logic [PKT_W-1:0]          decodedPacket2_i;
    logic [PKT_W-1:0]          decodedPacket3_i;
    logic [BC_W-1:0]           branchCount_i;
    logic                      stall_o;
    logic                      renameStall_i;
    logic                      renameReady_o;
    logic [PKT_W-1:0]          renamePacket0_o;
    logic [PKT_W-1:0]          renamePacket1_o;
    logic [PKT_W-1:0]          renamePacket2_o;
    logic [PKT_W-1:0]          renamePacket3_o;
    logic [BC_W-1:0]           renameBranchCount_o;
    logic [DEPTH_LOG:0]        occupancy_o;
    logic [BC_W+DEPTH_LOG-1:0] branchesQueued_o;

    modport master (
        output flush_i, decodeReady_i, decodedPacket0_i, decodedPacket1_i,
               decodedPacket2_i, decodedPacket3_i, branchCount_i, renameStall_i,
        input  stall_o, renameReady_o, renamePacket0_o, renamePacket1_o,
               renamePacket2_o, renamePacket3_o, renameBranchCount_o,
               occupancy_o, branchesQueued_o
    );

    modport slave (
        input  flush_i, decodeReady_i, decodedPacket0_i, decodedPacket1_i,
               decodedPacket2_i, decodedPacket3_i, branchCount_i, renameStall_i,
        output stall_o, renameReady_o, renamePacket0_o, renamePacket1_o,
               renamePacket2_o, renamePacket3_o, renameBranchCount_o,
               occupancy_o, branchesQueued_o
    );
endinterface
`default_nettype wire

// File: rtl/decode_rename_queue_bundle_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : decode_rename_queue_bundle_fifo_ctrl
// Brief  : Head/tail pointers, occupancy count and push/pop qualification.
// Rev    : 1.0  initial release
// ============================================================================
module decode_rename_queue_bundle_fifo_ctrl #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 flush,
    input  wire logic                 push_req,
    input  wire logic                 pop_req,
    output logic                      push,
    output logic                      pop,
    output logic [DEPTH_LOG-1:0]      head_ptr,
    output logic [DEPTH_LOG-1:0]      tail_ptr,
    output logic [DEPTH_LOG:0]        count,
    output logic                      full,
    output logic                      empty
);
    localparam logic [DEPTH_LOG:0] c_FULL = DEPTH[DEPTH_LOG:0];

    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;

    // full/empty come from registered count only, so stall has no input path
    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign push     = push_req & ~full & ~flush;
    assign pop      = pop_req & ~empty & ~flush;
    assign head_ptr = r_head;
    assign tail_ptr = r_tail;
    assign count    = r_count;

    // Power-of-two depth: pointer overflow is the DEPTH-1 -> 0 wrap
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + DEPTH_LOG'(1);
            if (pop)  r_head <= r_head + DEPTH_LOG'(1);
            if (push && !pop)      r_count <= r_count + (DEPTH_LOG+1)'(1);
            else if (pop && !push) r_count <= r_count - (DEPTH_LOG+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= c_FULL);
            assert (!(pop && empty));
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_rename_queue.sv
`default_nettype none
// ============================================================================
// Module : decode_rename_queue
// Brief  : Bundle FIFO between the Decode latch and Rename, with branch tally.
// Rev    : 1.0  initial release
// ============================================================================
module decode_rename_queue
    import decode_rename_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2,
    parameter int PKT_W     = c_DEC_PKT_WIDTH,
    parameter int BC_W      = c_BRANCH_COUNT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    decode_rename_queue_if.slave  bus
);
    localparam int c_BQ_W = BC_W + DEPTH_LOG;

    logic [3:0][PKT_W-1:0] r_pkt [DEPTH];
    logic [BC_W-1:0]       r_bc  [DEPTH];
    logic [c_BQ_W-1:0]     r_bq;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG-1:0]  w_head;
    logic [DEPTH_LOG-1:0]  w_tail;
    logic [DEPTH_LOG:0]    w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [BC_W-1:0]       w_head_bc;
    logic [c_BQ_W-1:0]     w_bq_next;
    logic [c_BQ_W-1:0]     w_stored_sum;

    decode_rename_queue_bundle_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.flush_i),
        .push_req (bus.decodeReady_i),
        .pop_req  (~bus.renameStall_i),
        .push     (w_push),
        .pop      (w_pop),
        .head_ptr (w_head),
        .tail_ptr (w_tail),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pkt[w_tail] <= {bus.decodedPacket3_i, bus.decodedPacket2_i,
                              bus.decodedPacket1_i, bus.decodedPacket0_i};
            r_bc[w_tail]  <= bus.branchCount_i;
        end
    end

    assign w_head_bc = r_bc[w_head];
    assign w_bq_next = r_bq
                     + (w_push ? c_BQ_W'(bus.branchCount_i) : '0)
                     - (w_pop  ? c_BQ_W'(w_head_bc)         : '0);

    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) r_bq <= '0;
        else                      r_bq <= w_bq_next;
    end

    assign bus.stall_o             = w_full;
    assign bus.renameReady_o       = ~w_empty;
    assign bus.renamePacket0_o     = r_pkt[w_head][0];
    assign bus.renamePacket1_o     = r_pkt[w_head][1];
    assign bus.renamePacket2_o     = r_pkt[w_head][2];
    assign bus.renamePacket3_o     = r_pkt[w_head][3];
    assign bus.renameBranchCount_o = w_head_bc;
    assign bus.occupancy_o         = w_count;
    assign bus.branchesQueued_o    = r_bq;

    // Sum of branch counts over live entries; only feeds the consistency check
    always_comb begin
        w_stored_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, DEPTH_LOG'(DEPTH_LOG'(i) - w_head)} < w_count)
                w_stored_sum = w_stored_sum + c_BQ_W'(r_bc[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (r_bq == w_stored_sum);
    end

endmodule
`default_nettype wire
